// File: rtl/ex_operand_collector.sv
// Four-entry operand collector: gathers up to two RF source operands per warp instruction
// and dispatches a fully collected entry one cycle after the EX issue unit grants it.
module ex_operand_collector #(
    parameter int NUM_OC  = 4,
    parameter int OPND_W  = 256,
    parameter int INSTR_W = 32,
    parameter int REG_W   = 5,
    parameter int WID_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Alloc_Valid,
    output logic               Alloc_Ready,
    input  logic [WID_W-1:0]   Alloc_WarpID,
    input  logic [INSTR_W-1:0] Alloc_Instr,
    input  logic [1:0]         Alloc_Src_Need,
    input  logic [REG_W-1:0]   Alloc_Src1_Reg,
    input  logic [REG_W-1:0]   Alloc_Src2_Reg,
    output logic               RF_Rd_Req,
    output logic [1:0]         RF_Rd_EntryID,
    output logic               RF_Rd_OpSel,
    output logic [WID_W-1:0]   RF_Rd_WarpID,
    output logic [REG_W-1:0]   RF_Rd_Reg,
    input  logic               RF_Rd_Gnt,
    input  logic               RF_Wb_Valid,
    input  logic [1:0]         RF_Wb_EntryID,
    input  logic               RF_Wb_OpSel,
    input  logic [OPND_W-1:0]  RF_Wb_Data,
    output logic [NUM_OC-1:0]  OC_IssReq_EX_IU,
    input  logic [NUM_OC-1:0]  EX_IU_Grant,
    output logic               OC_Iss_Valid,
    output logic [WID_W-1:0]   OC_Iss_WarpID,
    output logic [INSTR_W-1:0] OC_Iss_Instr,
    output logic [OPND_W-1:0]  OC_Iss_Src1,
    output logic [OPND_W-1:0]  OC_Iss_Src2,
    output logic               OC_Err
);

    localparam int IDX_W = 2;

    typedef enum logic [1:0] {
        OP_EMPTY = 2'd0,
        OP_REQD  = 2'd1,
        OP_READY = 2'd2
    } op_state_e;

    logic [NUM_OC-1:0]  valid_q, valid_d;
    logic [WID_W-1:0]   warp_q  [NUM_OC];
    logic [WID_W-1:0]   warp_d  [NUM_OC];
    logic [INSTR_W-1:0] instr_q [NUM_OC];
    logic [INSTR_W-1:0] instr_d [NUM_OC];
    logic [REG_W-1:0]   reg_q   [NUM_OC][2];
    logic [REG_W-1:0]   reg_d   [NUM_OC][2];
    op_state_e          st_q    [NUM_OC][2];
    op_state_e          st_d    [NUM_OC][2];
    logic [OPND_W-1:0]  data_q  [NUM_OC][2];
    logic [OPND_W-1:0]  data_d  [NUM_OC][2];

    logic               rd_lock_q, rd_lock_d;
    logic [IDX_W-1:0]   rd_ent_q, rd_ent_d;
    logic               rd_op_q, rd_op_d;

    logic               iss_valid_q, iss_valid_d;
    logic [WID_W-1:0]   iss_warp_q, iss_warp_d;
    logic [INSTR_W-1:0] iss_instr_q, iss_instr_d;
    logic [OPND_W-1:0]  iss_src1_q, iss_src1_d;
    logic [OPND_W-1:0]  iss_src2_q, iss_src2_d;
    logic               err_q, err_d;

    logic               alloc_ready;
    logic [IDX_W-1:0]   alloc_idx;
    logic               scan_found;
    logic [IDX_W-1:0]   scan_ent;
    logic               scan_op;
    logic               rd_req;
    logic [IDX_W-1:0]   rd_ent;
    logic               rd_op;
    logic [NUM_OC-1:0]  iss_req;
    logic               gnt_onehot;
    logic               gnt_ok;
    logic [IDX_W-1:0]   gnt_idx;
    logic               wb_ok;

    always_comb begin
        alloc_ready = ~&valid_q;
        alloc_idx   = '0;
        scan_found  = 1'b0;
        scan_ent    = '0;
        scan_op     = 1'b0;
        gnt_idx     = '0;
        for (int i = NUM_OC - 1; i >= 0; i--) begin
            if (!valid_q[i]) alloc_idx = IDX_W'(i);
            // Later hits override earlier ones: lowest entry wins, src1 before src2.
            if (valid_q[i] && st_q[i][1] == OP_EMPTY) begin
                scan_found = 1'b1;
                scan_ent   = IDX_W'(i);
                scan_op    = 1'b1;
            end
            if (valid_q[i] && st_q[i][0] == OP_EMPTY) begin
                scan_found = 1'b1;
                scan_ent   = IDX_W'(i);
                scan_op    = 1'b0;
            end
            if (EX_IU_Grant[i]) gnt_idx = IDX_W'(i);
            iss_req[i] = valid_q[i] && st_q[i][0] == OP_READY && st_q[i][1] == OP_READY;
        end
    end

    // An ungranted request stays pinned even if a lower entry is allocated meanwhile.
    assign rd_req = rd_lock_q | scan_found;
    assign rd_ent = rd_lock_q ? rd_ent_q : scan_ent;
    assign rd_op  = rd_lock_q ? rd_op_q : scan_op;

    assign gnt_onehot = (EX_IU_Grant != '0) && ((EX_IU_Grant & (EX_IU_Grant - 4'd1)) == '0);
    assign gnt_ok     = gnt_onehot && iss_req[gnt_idx];
    assign wb_ok      = valid_q[RF_Wb_EntryID] && st_q[RF_Wb_EntryID][RF_Wb_OpSel] == OP_REQD;

    always_comb begin
        valid_d     = valid_q;
        warp_d      = warp_q;
        instr_d     = instr_q;
        reg_d       = reg_q;
        st_d        = st_q;
        data_d      = data_q;
        rd_lock_d   = rd_req & ~RF_Rd_Gnt;
        rd_ent_d    = rd_ent;
        rd_op_d     = rd_op;
        iss_valid_d = 1'b0;
        iss_warp_d  = iss_warp_q;
        iss_instr_d = iss_instr_q;
        iss_src1_d  = iss_src1_q;
        iss_src2_d  = iss_src2_q;
        err_d       = err_q;

        if (rd_req && RF_Rd_Gnt) st_d[rd_ent][rd_op] = OP_REQD;

        if (RF_Wb_Valid) begin
            if (wb_ok) begin
                data_d[RF_Wb_EntryID][RF_Wb_OpSel] = RF_Wb_Data;
                st_d[RF_Wb_EntryID][RF_Wb_OpSel]   = OP_READY;
            end else begin
                err_d = 1'b1;
            end
        end

        if (gnt_ok) begin
            iss_valid_d      = 1'b1;
            iss_warp_d       = warp_q[gnt_idx];
            iss_instr_d      = instr_q[gnt_idx];
            iss_src1_d       = data_q[gnt_idx][0];
            iss_src2_d       = data_q[gnt_idx][1];
            valid_d[gnt_idx] = 1'b0;
        end else if (EX_IU_Grant != '0) begin
            err_d = 1'b1;
        end

        // Operands not needed start READY with zero data, so dispatch shows 0 for them.
        if (Alloc_Valid && alloc_ready) begin
            valid_d[alloc_idx]    = 1'b1;
            warp_d[alloc_idx]     = Alloc_WarpID;
            instr_d[alloc_idx]    = Alloc_Instr;
            reg_d[alloc_idx][0]   = Alloc_Src1_Reg;
            reg_d[alloc_idx][1]   = Alloc_Src2_Reg;
            st_d[alloc_idx][0]    = Alloc_Src_Need[0] ? OP_EMPTY : OP_READY;
            st_d[alloc_idx][1]    = Alloc_Src_Need[1] ? OP_EMPTY : OP_READY;
            data_d[alloc_idx][0]  = '0;
            data_d[alloc_idx][1]  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= '0;
            rd_lock_q   <= 1'b0;
            rd_ent_q    <= '0;
            rd_op_q     <= 1'b0;
            iss_valid_q <= 1'b0;
            iss_warp_q  <= '0;
            iss_instr_q <= '0;
            iss_src1_q  <= '0;
            iss_src2_q  <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < NUM_OC; i++) begin
                warp_q[i]  <= '0;
                instr_q[i] <= '0;
                for (int k = 0; k < 2; k++) begin
                    reg_q[i][k]  <= '0;
                    st_q[i][k]   <= OP_EMPTY;
                    data_q[i][k] <= '0;
                end
            end
        end else begin
            valid_q     <= valid_d;
            warp_q      <= warp_d;
            instr_q     <= instr_d;
            reg_q       <= reg_d;
            st_q        <= st_d;
            data_q      <= data_d;
            rd_lock_q   <= rd_lock_d;
            rd_ent_q    <= rd_ent_d;
            rd_op_q     <= rd_op_d;
            iss_valid_q <= iss_valid_d;
            iss_warp_q  <= iss_warp_d;
            iss_instr_q <= iss_instr_d;
            iss_src1_q  <= iss_src1_d;
            iss_src2_q  <= iss_src2_d;
            err_q       <= err_d;
        end
    end

    assign Alloc_Ready     = alloc_ready;
    assign RF_Rd_Req       = rd_req;
    assign RF_Rd_EntryID   = rd_req ? rd_ent : '0;
    assign RF_Rd_OpSel     = rd_req & rd_op;
    assign RF_Rd_WarpID    = rd_req ? warp_q[rd_ent] : '0;
    assign RF_Rd_Reg       = rd_req ? reg_q[rd_ent][rd_op] : '0;
    assign OC_IssReq_EX_IU = iss_req;
    assign OC_Iss_Valid    = iss_valid_q;
    assign OC_Iss_WarpID   = iss_warp_q;
    assign OC_Iss_Instr    = iss_instr_q;
    assign OC_Iss_Src1     = iss_src1_q;
    assign OC_Iss_Src2     = iss_src2_q;
    assign OC_Err          = err_q;

endmodule

// File: tb/tb_ex_operand_collector.sv
// Bench for ex_operand_collector: directed scenarios followed by random traffic, checked
// every cycle against a per-entry operand-status model of the collector.
module tb_ex_operand_collector;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         Alloc_Valid;
    logic         Alloc_Ready;
    logic [2:0]   Alloc_WarpID;
    logic [31:0]  Alloc_Instr;
    logic [1:0]   Alloc_Src_Need;
    logic [4:0]   Alloc_Src1_Reg;
    logic [4:0]   Alloc_Src2_Reg;
    logic         RF_Rd_Req;
    logic [1:0]   RF_Rd_EntryID;
    logic         RF_Rd_OpSel;
    logic [2:0]   RF_Rd_WarpID;
    logic [4:0]   RF_Rd_Reg;
    logic         RF_Rd_Gnt;
    logic         RF_Wb_Valid;
    logic [1:0]   RF_Wb_EntryID;
    logic         RF_Wb_OpSel;
    logic [255:0] RF_Wb_Data;
    logic [3:0]   OC_IssReq_EX_IU;
    logic [3:0]   EX_IU_Grant;
    logic         OC_Iss_Valid;
    logic [2:0]   OC_Iss_WarpID;
    logic [31:0]  OC_Iss_Instr;
    logic [255:0] OC_Iss_Src1;
    logic [255:0] OC_Iss_Src2;
    logic         OC_Err;

    ex_operand_collector dut (
        .clk(clk), .rst(rst),
        .Alloc_Valid(Alloc_Valid), .Alloc_Ready(Alloc_Ready), .Alloc_WarpID(Alloc_WarpID),
        .Alloc_Instr(Alloc_Instr), .Alloc_Src_Need(Alloc_Src_Need),
        .Alloc_Src1_Reg(Alloc_Src1_Reg), .Alloc_Src2_Reg(Alloc_Src2_Reg),
        .RF_Rd_Req(RF_Rd_Req), .RF_Rd_EntryID(RF_Rd_EntryID), .RF_Rd_OpSel(RF_Rd_OpSel),
        .RF_Rd_WarpID(RF_Rd_WarpID), .RF_Rd_Reg(RF_Rd_Reg), .RF_Rd_Gnt(RF_Rd_Gnt),
        .RF_Wb_Valid(RF_Wb_Valid), .RF_Wb_EntryID(RF_Wb_EntryID), .RF_Wb_OpSel(RF_Wb_OpSel),
        .RF_Wb_Data(RF_Wb_Data), .OC_IssReq_EX_IU(OC_IssReq_EX_IU), .EX_IU_Grant(EX_IU_Grant),
        .OC_Iss_Valid(OC_Iss_Valid), .OC_Iss_WarpID(OC_Iss_WarpID), .OC_Iss_Instr(OC_Iss_Instr),
        .OC_Iss_Src1(OC_Iss_Src1), .OC_Iss_Src2(OC_Iss_Src2), .OC_Err(OC_Err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: operand status 0 = waiting for read, 1 = read granted, 2 = data present.
    bit           m_valid [4];
    int           m_st    [4][2];
    logic [255:0] m_data  [4][2];
    logic [4:0]   m_reg   [4][2];
    logic [2:0]   m_warp  [4];
    logic [31:0]  m_instr [4];
    bit           m_err;
    bit           m_iss_v;
    logic [2:0]   m_iss_w;
    logic [31:0]  m_iss_i;
    logic [255:0] m_iss_s1, m_iss_s2;
    bit           m_hold;
    int           m_hold_e, m_hold_op;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready(int i);
        return m_valid[i] && m_st[i][0] == 2 && m_st[i][1] == 2;
    endfunction

    function automatic logic [3:0] m_reqvec();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_ready(i);
        return v;
    endfunction

    task automatic m_read(output bit req, output int e, output int op);
        req = 0; e = 0; op = 0;
        if (m_hold) begin
            req = 1; e = m_hold_e; op = m_hold_op;
        end else begin
            for (int i = 3; i >= 0; i--)
                for (int k = 1; k >= 0; k--)
                    if (m_valid[i] && m_st[i][k] == 0) begin req = 1; e = i; op = k; end
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 0; m_warp[i] = '0; m_instr[i] = '0;
            for (int k = 0; k < 2; k++) begin m_st[i][k] = 0; m_data[i][k] = '0; m_reg[i][k] = '0; end
        end
        m_err = 0; m_iss_v = 0; m_iss_w = '0; m_iss_i = '0; m_iss_s1 = '0; m_iss_s2 = '0;
        m_hold = 0; m_hold_e = 0; m_hold_op = 0;
    endtask

    task automatic m_edge();
        bit req; int e, op; int free_i; logic [3:0] rv; int ones; int gi;
        m_read(req, e, op);
        rv = m_reqvec();
        free_i = -1;
        for (int i = 3; i >= 0; i--) if (!m_valid[i]) free_i = i;
        if (RF_Wb_Valid) begin
            if (m_valid[RF_Wb_EntryID] && m_st[RF_Wb_EntryID][RF_Wb_OpSel] == 1) begin
                m_data[RF_Wb_EntryID][RF_Wb_OpSel] = RF_Wb_Data;
                m_st[RF_Wb_EntryID][RF_Wb_OpSel] = 2;
            end else m_err = 1;
        end
        ones = 0; gi = 0;
        for (int i = 0; i < 4; i++) if (EX_IU_Grant[i]) begin ones++; gi = i; end
        m_iss_v = 0;
        if (ones == 1 && rv[gi]) begin
            m_iss_v = 1; m_iss_w = m_warp[gi]; m_iss_i = m_instr[gi];
            m_iss_s1 = m_data[gi][0]; m_iss_s2 = m_data[gi][1];
            m_valid[gi] = 0;
        end else if (ones != 0) m_err = 1;
        if (req && RF_Rd_Gnt) begin m_st[e][op] = 1; m_hold = 0; end
        else if (req) begin m_hold = 1; m_hold_e = e; m_hold_op = op; end
        else m_hold = 0;
        if (Alloc_Valid && free_i >= 0) begin
            m_valid[free_i] = 1; m_warp[free_i] = Alloc_WarpID; m_instr[free_i] = Alloc_Instr;
            m_reg[free_i][0] = Alloc_Src1_Reg; m_reg[free_i][1] = Alloc_Src2_Reg;
            m_st[free_i][0] = Alloc_Src_Need[0] ? 0 : 2;
            m_st[free_i][1] = Alloc_Src_Need[1] ? 0 : 2;
            m_data[free_i][0] = '0; m_data[free_i][1] = '0;
        end
    endtask

    task automatic check_all();
        bit req; int e, op; bit any_free;
        m_read(req, e, op);
        any_free = 0;
        for (int i = 0; i < 4; i++) if (!m_valid[i]) any_free = 1;
        chk("alloc_ready", Alloc_Ready, any_free);
        chk("rd_req", RF_Rd_Req, req);
        if (req) begin
            chk("rd_entry", RF_Rd_EntryID, e);
            chk("rd_opsel", RF_Rd_OpSel, op);
            chk("rd_warp", RF_Rd_WarpID, m_warp[e]);
            chk("rd_reg", RF_Rd_Reg, m_reg[e][op]);
        end
        chk("issreq", OC_IssReq_EX_IU, m_reqvec());
        chk("iss_valid", OC_Iss_Valid, m_iss_v);
        chk("iss_warp", OC_Iss_WarpID, m_iss_w);
        chk("iss_instr", OC_Iss_Instr, m_iss_i);
        chk("iss_src1", OC_Iss_Src1, m_iss_s1);
        chk("iss_src2", OC_Iss_Src2, m_iss_s2);
        chk("oc_err", OC_Err, m_err);
    endtask

    task automatic idle();
        Alloc_Valid = 0; Alloc_WarpID = '0; Alloc_Instr = '0; Alloc_Src_Need = '0;
        Alloc_Src1_Reg = '0; Alloc_Src2_Reg = '0; RF_Rd_Gnt = 0;
        RF_Wb_Valid = 0; RF_Wb_EntryID = '0; RF_Wb_OpSel = 0; RF_Wb_Data = '0; EX_IU_Grant = '0;
    endtask

    task automatic cycle();
        @(posedge clk);
        m_edge();
        #1;
        check_all();
        idle();
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        m_reset();
        @(posedge clk);
        #1;
        rst = 0;
        check_all();
    endtask

    task automatic alloc(input logic [2:0] w, input logic [31:0] ins, input logic [1:0] need,
                         input logic [4:0] r1, input logic [4:0] r2);
        Alloc_Valid = 1; Alloc_WarpID = w; Alloc_Instr = ins; Alloc_Src_Need = need;
        Alloc_Src1_Reg = r1; Alloc_Src2_Reg = r2;
    endtask

    task automatic wb(input int e, input int op, input logic [255:0] d);
        RF_Wb_Valid = 1; RF_Wb_EntryID = 2'(e); RF_Wb_OpSel = 1'(op); RF_Wb_Data = d;
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        logic [255:0] d1, d2;
        int cand [$];
        int pick;

        idle();
        #2;
        m_reset();
        do_reset();
        chk("t1_reset_ready", Alloc_Ready, 1'b1);
        chk("t1_reset_rdreq", RF_Rd_Req, 1'b0);
        chk("t1_reset_issreq", OC_IssReq_EX_IU, 4'b0000);
        chk("t1_reset_err", OC_Err, 1'b0);

        // 1: single instruction end to end
        alloc(3'd2, 32'hA5A5_0001, 2'b11, 5'd3, 5'd7);
        cycle();
        chk("t1_rd1_reg", RF_Rd_Reg, 5'd3);
        chk("t1_rd1_op", RF_Rd_OpSel, 1'b0);
        RF_Rd_Gnt = 1;
        cycle();
        chk("t1_rd2_reg", RF_Rd_Reg, 5'd7);
        chk("t1_rd2_op", RF_Rd_OpSel, 1'b1);
        RF_Rd_Gnt = 1;
        cycle();
        chk("t1_rd_done", RF_Rd_Req, 1'b0);
        d1 = rand256(); d2 = rand256();
        wb(0, 0, d1);
        cycle();
        chk("t1_half_ready", OC_IssReq_EX_IU, 4'b0000);
        wb(0, 1, d2);
        cycle();
        chk("t1_issreq", OC_IssReq_EX_IU, 4'b0001);
        EX_IU_Grant = 4'b0001;
        cycle();
        chk("t1_iss_valid", OC_Iss_Valid, 1'b1);
        chk("t1_iss_src1", OC_Iss_Src1, d1);
        chk("t1_iss_src2", OC_Iss_Src2, d2);
        chk("t1_iss_warp", OC_Iss_WarpID, 3'd2);
        cycle();
        chk("t1_iss_pulse", OC_Iss_Valid, 1'b0);

        // 2: fill, dispatch entry 2, refill entry 2
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alloc(3'(i + 4), 32'h1000 + i, 2'b00, 5'd0, 5'd0);
            cycle();
        end
        chk("t2_full", Alloc_Ready, 1'b0);
        chk("t2_issreq", OC_IssReq_EX_IU, 4'b1111);
        EX_IU_Grant = 4'b0100;
        cycle();
        chk("t2_iss_warp", OC_Iss_WarpID, 3'd6);
        chk("t2_freed", Alloc_Ready, 1'b1);
        chk("t2_issreq_after", OC_IssReq_EX_IU, 4'b1011);
        alloc(3'd1, 32'hBEEF, 2'b00, 5'd0, 5'd0);
        cycle();
        chk("t2_refill", OC_IssReq_EX_IU, 4'b1111);
        EX_IU_Grant = 4'b0100;
        cycle();
        chk("t2_refill_instr", OC_Iss_Instr, 32'hBEEF);

        // 3: suppressed grant keeps the request
        do_reset();
        alloc(3'd3, 32'h33, 2'b00, 5'd0, 5'd0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            EX_IU_Grant = 4'b0000;
            cycle();
            chk("t3_req_holds", OC_IssReq_EX_IU[0], 1'b1);
            chk("t3_no_iss", OC_Iss_Valid, 1'b0);
        end

        // 4: read held without grant, then a writeback to an unrequested operand
        do_reset();
        alloc(3'd1, 32'h41, 2'b11, 5'd9, 5'd10);
        cycle();
        alloc(3'd2, 32'h42, 2'b11, 5'd11, 5'd12);
        cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t4_rd_hold_reg", RF_Rd_Reg, 5'd9);
            chk("t4_rd_hold_ent", RF_Rd_EntryID, 2'd0);
        end
        chk("t4_err_clear", OC_Err, 1'b0);
        wb(1, 0, rand256());
        cycle();
        chk("t4_err_set", OC_Err, 1'b1);
        chk("t4_still_empty", OC_IssReq_EX_IU, 4'b0000);

        // 5: grant to a non-requesting entry, and a non-one-hot grant
        do_reset();
        alloc(3'd0, 32'h50, 2'b00, 5'd0, 5'd0);
        cycle();
        alloc(3'd1, 32'h51, 2'b01, 5'd4, 5'd0);
        cycle();
        EX_IU_Grant = 4'b0010;
        cycle();
        chk("t5_bad_gnt_err", OC_Err, 1'b1);
        chk("t5_bad_gnt_noiss", OC_Iss_Valid, 1'b0);
        do_reset();
        alloc(3'd0, 32'h52, 2'b00, 5'd0, 5'd0);
        cycle();
        alloc(3'd1, 32'h53, 2'b00, 5'd0, 5'd0);
        cycle();
        EX_IU_Grant = 4'b0011;
        cycle();
        chk("t5_multi_err", OC_Err, 1'b1);
        chk("t5_multi_noiss", OC_Iss_Valid, 1'b0);
        chk("t5_multi_req", OC_IssReq_EX_IU, 4'b0011);

        // 6: reset while entries are mid-collection
        do_reset();
        alloc(3'd5, 32'h60, 2'b00, 5'd0, 5'd0);
        cycle();
        alloc(3'd6, 32'h61, 2'b11, 5'd1, 5'd2);
        cycle();
        alloc(3'd7, 32'h62, 2'b10, 5'd3, 5'd4);
        RF_Rd_Gnt = 1;
        cycle();
        EX_IU_Grant = 4'b0001;
        #2;
        rst = 1;
        #1;
        m_reset();
        chk("t6_rst_ready", Alloc_Ready, 1'b1);
        chk("t6_rst_rdreq", RF_Rd_Req, 1'b0);
        chk("t6_rst_issreq", OC_IssReq_EX_IU, 4'b0000);
        @(posedge clk);
        #1;
        chk("t6_rst_noiss", OC_Iss_Valid, 1'b0);
        idle();
        rst = 0;
        check_all();

        // random traffic: legal writebacks and grants only
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(2) != 0)
                alloc(3'($urandom), $urandom, 2'($urandom), 5'($urandom), 5'($urandom));
            RF_Rd_Gnt = 1'($urandom);
            cand.delete();
            for (int i = 0; i < 4; i++)
                for (int k = 0; k < 2; k++)
                    if (m_valid[i] && m_st[i][k] == 1) cand.push_back(i * 2 + k);
            if (cand.size() > 0 && $urandom_range(2) != 0) begin
                pick = cand[$urandom_range(cand.size() - 1)];
                wb(pick / 2, pick % 2, rand256());
            end
            cand.delete();
            for (int i = 0; i < 4; i++) if (m_ready(i)) cand.push_back(i);
            if (cand.size() > 0 && $urandom_range(3) != 0)
                EX_IU_Grant = 4'(1 << cand[$urandom_range(cand.size() - 1)]);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
